// File: rtl/beat_detector.sv
// Beat detector: measures the clock count between rising edges of a beat
// input, classifies each period against eight nominal rates, and reports a
// locked rate code once enough consecutive periods agree.
module beat_detector #(
  parameter int unsigned TOL        = 1024,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned TIMEOUT    = 100001025,
  // Nominal periods (clocks per beat) for rate codes 000..111
  parameter int unsigned N0         = 100000000,
  parameter int unsigned N1         = 66666667,
  parameter int unsigned N2         = 50000000,
  parameter int unsigned N3         = 40000000,
  parameter int unsigned N4         = 30000000,
  parameter int unsigned N5         = 20000000,
  parameter int unsigned N6         = 12000000,
  parameter int unsigned N7         = 6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulse,
  output logic [2:0]  rate,
  output logic        locked,
  output logic [27:0] period,
  output logic        beat_err
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [27:0] CNT_MAX   = 28'hFFF_FFFF;
  localparam logic [3:0]  LOCK_L    = 4'(LOCK_COUNT);
  localparam logic [27:0] TIMEOUT_L = 28'(TIMEOUT);
  localparam logic [28:0] TOL_L     = 29'(TOL);

  state_t      state_r, state_nx_s;
  logic [27:0] cnt_r, cnt_nx_s;
  logic        pulse_q_r;
  logic        armed_r;
  logic [2:0]  cand_r, cand_nx_s;
  logic [3:0]  mc_r, mc_nx_s;
  logic [2:0]  rate_r, rate_nx_s;
  logic        locked_r, locked_nx_s;
  logic [27:0] period_r, period_nx_s;
  logic        err_r, err_nx_s;
  logic        edge_s;
  logic        hit_s;
  logic [2:0]  hit_code_s;

  // Nominal period for a rate code
  function automatic logic [27:0] nominal(input logic [2:0] c);
    case (c)
      3'd0:    nominal = 28'(N0);
      3'd1:    nominal = 28'(N1);
      3'd2:    nominal = 28'(N2);
      3'd3:    nominal = 28'(N3);
      3'd4:    nominal = 28'(N4);
      3'd5:    nominal = 28'(N5);
      3'd6:    nominal = 28'(N6);
      3'd7:    nominal = 28'(N7);
      default: nominal = 28'(N0);
    endcase
  endfunction

  // |p - n| <= TOL in 29-bit signed arithmetic so the difference never wraps
  function automatic logic within_tol(input logic [27:0] p, input logic [27:0] n);
    logic signed [28:0] d;
    logic [28:0]        mag;
    d = $signed({1'b0, p}) - $signed({1'b0, n});
    if (d < 29'sd0) begin
      mag = 29'(-d);
    end else begin
      mag = 29'(d);
    end
    within_tol = (mag <= TOL_L);
  endfunction

  // Armed only after pulse has been seen low, so a pulse held high through
  // reset release cannot masquerade as a rising edge
  assign edge_s = pulse & ~pulse_q_r & armed_r;

  // Classify the running count against every nominal period
  always_comb begin
    hit_s      = 1'b0;
    hit_code_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (within_tol(cnt_r, nominal(3'(i)))) begin
        hit_s      = 1'b1;
        hit_code_s = 3'(i);
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Next-state and next-output logic for the measurement FSM
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    cand_nx_s   = cand_r;
    mc_nx_s     = mc_r;
    rate_nx_s   = rate_r;
    locked_nx_s = locked_r;
    period_nx_s = period_r;
    err_nx_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_nx_s = MEASURE;
          cnt_nx_s   = 28'd1;
        end else begin
          cnt_nx_s   = cnt_r;
        end
      end
      MEASURE: begin
        if (edge_s) begin
          cnt_nx_s    = 28'd1;
          period_nx_s = cnt_r;
          if (hit_s) begin
            if (hit_code_s == cand_r) begin
              mc_nx_s = (mc_r >= LOCK_L) ? LOCK_L : (mc_r + 4'd1);
            end else begin
              cand_nx_s = hit_code_s;
              mc_nx_s   = 4'd1;
            end
            if (mc_nx_s == LOCK_L) begin
              locked_nx_s = 1'b1;
              rate_nx_s   = cand_nx_s;
            end else begin
              locked_nx_s = 1'b0;
            end
          end else begin
            err_nx_s    = 1'b1;
            mc_nx_s     = 4'd0;
            locked_nx_s = 1'b0;
          end
        end else if (cnt_r == TIMEOUT_L) begin
          state_nx_s  = IDLE;
          locked_nx_s = 1'b0;
          mc_nx_s     = 4'd0;
        end else if (cnt_r != CNT_MAX) begin
          cnt_nx_s = cnt_r + 28'd1;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 28'd0;
      pulse_q_r <= 1'b0;
      armed_r   <= 1'b0;
      cand_r    <= 3'd0;
      mc_r      <= 4'd0;
      rate_r    <= 3'd0;
      locked_r  <= 1'b0;
      period_r  <= 28'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      pulse_q_r <= pulse;
      armed_r   <= armed_r | ~pulse;
      cand_r    <= cand_nx_s;
      mc_r      <= mc_nx_s;
      rate_r    <= rate_nx_s;
      locked_r  <= locked_nx_s;
      period_r  <= period_nx_s;
      err_r     <= err_nx_s;
    end
  end

  assign rate     = rate_r;
  assign locked   = locked_r;
  assign period   = period_r;
  assign beat_err = err_r;

endmodule

// File: tb/tb_beat_detector.sv
// Directed testbench for beat_detector with scaled-down nominal periods.
module tb_beat_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse;
  logic [2:0]  rate;
  logic        locked;
  logic [27:0] period;
  logic        beat_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam int TIMEOUT = 1500;

  beat_detector #(
    .TOL(40), .LOCK_COUNT(2), .TIMEOUT(TIMEOUT),
    .N0(1000), .N1(800), .N2(600), .N3(500),
    .N4(400), .N5(300), .N6(200), .N7(100)
  ) dut (
    .clk(clk), .reset(reset), .pulse(pulse),
    .rate(rate), .locked(locked), .period(period), .beat_err(beat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int w;
    int exp_period;
    int exp_locked;
    int exp_rate;
    int exp_err;
  } vec_t;

  vec_t vec [18];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input int p, input int l, input int r, input int e);
    check({name, ".period"}, int'(period), p);
    check({name, ".locked"}, int'(locked), l);
    check({name, ".rate"}, int'(rate), r);
    check({name, ".beat_err"}, int'(beat_err), e);
  endtask

  // Called 1ns after a clock edge with pulse low: next edge is processed at
  // the following clock edge; returns 1ns after that edge.
  task automatic first_edge();
    pulse = 1'b1;
    @(posedge clk); #1;
  endtask

  // Starts 1ns after the previous edge cycle; produces a rising edge gap
  // cycles later with a high time of w cycles; returns 1ns after the edge.
  task automatic beat(input int gap, input int w);
    if (w <= 1) pulse = 1'b0;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("err_one_cycle", int'(beat_err), 0);
      if (i >= w - 1) pulse = 1'b0;
    end
    pulse = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0]  = '{100,  1, 100,  0, 0, 0};
    vec[1]  = '{100,  1, 100,  1, 7, 0};
    vec[2]  = '{100,  5, 100,  1, 7, 0};
    vec[3]  = '{100,  5, 100,  1, 7, 0};
    vec[4]  = '{200,  1, 200,  0, 7, 0};
    vec[5]  = '{200,  3, 200,  1, 6, 0};
    vec[6]  = '{100,  1, 100,  0, 6, 0};
    vec[7]  = '{140,  1, 140,  1, 7, 0};
    vec[8]  = '{141,  1, 141,  0, 7, 1};
    vec[9]  = '{60,   1, 60,   0, 7, 0};
    vec[10] = '{59,   1, 59,   0, 7, 1};
    vec[11] = '{1000, 1, 1000, 0, 7, 0};
    vec[12] = '{1040, 1, 1040, 1, 0, 0};
    vec[13] = '{500,  1, 500,  0, 0, 0};
    vec[14] = '{460,  2, 460,  1, 3, 0};
    vec[15] = '{800,  1, 800,  0, 3, 0};
    vec[16] = '{760,  1, 760,  1, 1, 0};
    vec[17] = '{1200, 1, 1200, 0, 1, 1};

    reset = 1'b0;
    pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_state", 0, 0, 0, 0);

    // Reference edge from IDLE: no measurement, no output change
    first_edge();
    check_outs("idle_ref_edge", 0, 0, 0, 0);

    for (int k = 0; k < 18; k++) begin
      beat(vec[k].gap, vec[k].w);
      check_outs($sformatf("vec%0d", k), vec[k].exp_period, vec[k].exp_locked,
                 vec[k].exp_rate, vec[k].exp_err);
    end

    // Timeout while locked
    beat(100, 1);
    check_outs("relock_a1", 100, 0, 1, 0);
    beat(100, 1);
    check_outs("relock_a2", 100, 1, 7, 0);
    pulse = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("pre_timeout.locked", int'(locked), 1);
    @(posedge clk); #1;
    check_outs("timeout", 100, 0, 7, 0);
    first_edge();
    check_outs("after_timeout_ref", 100, 0, 7, 0);
    beat(200, 1);
    check_outs("after_timeout_meas", 200, 0, 7, 0);
    // Edge lands exactly on the timeout count: measured, not dropped
    beat(TIMEOUT, 1);
    check_outs("edge_at_timeout", TIMEOUT, 0, 7, 1);

    // Asynchronous reset mid-period while locked
    beat(100, 1);
    check_outs("relock_b1", 100, 0, 7, 0);
    beat(100, 1);
    check_outs("relock_b2", 100, 1, 7, 0);
    pulse = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0);
    pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outs("held_pulse_release", 0, 0, 0, 0);
    pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    first_edge();
    check_outs("post_reset_ref", 0, 0, 0, 0);
    beat(100, 1);
    check_outs("post_reset_m1", 100, 0, 0, 0);
    beat(100, 1);
    check_outs("post_reset_m2", 100, 1, 7, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
